// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB pipeline register built as a 2-entry skid buffer.
//               A main (output) register feeds the WB stage. A skid register
//               catches one extra entry when WB stalls. in_ready depends only
//               on registered state, so there is no combinational path from
//               out_ready to in_ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   flush             : drop every held entry at the next edge
//   in_valid/in_ready : MEM-side handshake
//   control_wb_in     : [1]=regwrite, [0]=memtoreg
//   read_data_in      : data-memory read value
//   alu_result_in     : ALU result
//   write_reg_in      : destination register index
//   out_valid/out_ready : WB-side handshake
//   regwrite          : write enable, gated by out_valid and a non-zero dest
//   memtoreg, read_data, mem_alu_result, mem_write_reg : held main entry
//   wb_data           : memtoreg ? read_data : mem_alu_result
//   count             : entries held (0..2)
// Optional (macro MEM_WB_PIPE_FWD_EN):
//   fwd_rs, fwd_rt    : source register indices to compare against
//   fwd_rs_hit, fwd_rt_hit, fwd_data : combinational forwarding result
// ============================================================================
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        control_wb_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_W-1:0]  write_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              regwrite,
    output logic              memtoreg,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic [DATA_W-1:0] wb_data,
`ifdef MEM_WB_PIPE_FWD_EN
    input  logic [REG_W-1:0]  fwd_rs,
    input  logic [REG_W-1:0]  fwd_rt,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [1:0]        count
);

    // Packed entry layout: {ctrl[1:0], read_data, alu_result, write_reg}
    localparam int c_ENTRY_W = 2 + 2 * DATA_W + REG_W;

    logic [c_ENTRY_W-1:0] w_in_entry;
    logic [c_ENTRY_W-1:0] r_main;
    logic [c_ENTRY_W-1:0] r_skid;
    logic                 r_main_valid;
    logic                 r_skid_valid;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_load_main;
    logic                 w_load_skid;
    logic                 w_skid_to_main;
    logic [1:0]           w_ctrl;

    assign w_in_entry = {control_wb_in, read_data_in, alu_result_in, write_reg_in};

    assign in_ready = !r_skid_valid;
    assign w_in_hs  = in_valid && !r_skid_valid;
    assign w_out_hs = r_main_valid && out_ready;

    // An accepted entry goes straight to main whenever main is (or becomes)
    // free this cycle; otherwise it parks in skid. The skid can only be full
    // when in_ready is low, so skid->main and an input load never coincide.
    // Flush suppresses every load, including the data registers.
    assign w_skid_to_main = r_skid_valid && w_out_hs && !flush;
    assign w_load_main    = w_in_hs && (!r_main_valid || w_out_hs) && !flush;
    assign w_load_skid    = w_in_hs && r_main_valid && !w_out_hs && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_skid_to_main) begin
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
        end else if (w_load_main) begin
            r_main_valid <= 1'b1;
        end else if (w_load_skid) begin
            r_skid_valid <= 1'b1;
        end else if (w_out_hs) begin
            r_main_valid <= 1'b0;
        end
    end

    // Data registers only change on a load; they keep their contents when
    // drained or flushed so the outputs hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_skid_to_main) begin
                r_main <= r_skid;
            end else if (w_load_main) begin
                r_main <= w_in_entry;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign {w_ctrl, read_data, mem_alu_result, mem_write_reg} = r_main;

    assign out_valid = r_main_valid;
    assign memtoreg  = w_ctrl[0];
    // Register 0 is hard-wired zero, so writes to it are suppressed here.
    assign regwrite  = w_ctrl[1] && r_main_valid && (mem_write_reg != '0);
    assign wb_data   = w_ctrl[0] ? read_data : mem_alu_result;
    assign count     = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

`ifdef MEM_WB_PIPE_FWD_EN
    assign fwd_rs_hit = regwrite && (mem_write_reg == fwd_rs);
    assign fwd_rt_hit = regwrite && (mem_write_reg == fwd_rt);
    assign fwd_data   = wb_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe
// Description : Self-checking bench for mem_wb_pipe. A queue holds the
//               entries the block should currently contain; its head is the
//               expected main entry, and the last head is kept to check that
//               outputs hold their value when nothing is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  control_wb_in;
    logic [31:0] read_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  write_reg_in;
    logic        out_valid;
    logic        out_ready;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic [31:0] wb_data;
    logic [1:0]  count;
`ifdef MEM_WB_PIPE_FWD_EN
    logic [4:0]  fwd_rs;
    logic [4:0]  fwd_rt;
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [31:0] fwd_data;
`endif

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];
    ent_t last;

    mem_wb_pipe #(.DATA_W(32), .REG_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .control_wb_in  (control_wb_in),
        .read_data_in   (read_data_in),
        .alu_result_in  (alu_result_in),
        .write_reg_in   (write_reg_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .regwrite       (regwrite),
        .memtoreg       (memtoreg),
        .read_data      (read_data),
        .mem_alu_result (mem_alu_result),
        .mem_write_reg  (mem_write_reg),
        .wb_data        (wb_data),
`ifdef MEM_WB_PIPE_FWD_EN
        .fwd_rs         (fwd_rs),
        .fwd_rt         (fwd_rt),
        .fwd_rs_hit     (fwd_rs_hit),
        .fwd_rt_hit     (fwd_rt_hit),
        .fwd_data       (fwd_data),
`endif
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model state for the current cycle.
    task automatic check_outputs();
        ent_t e;
        int   n;
        n = sb.size();
        e = (n > 0) ? sb[0] : last;
        chk("count",     64'(count),     64'(n));
        chk("in_ready",  64'(in_ready),  64'(n < 2));
        chk("out_valid", 64'(out_valid), 64'(n > 0));
        chk("memtoreg",  64'(memtoreg),  64'(e.ctrl[0]));
        chk("read_data", 64'(read_data), 64'(e.rd));
        chk("alu",       64'(mem_alu_result), 64'(e.alu));
        chk("wr",        64'(mem_write_reg),  64'(e.wr));
        chk("wb_data",   64'(wb_data),   64'(e.ctrl[0] ? e.rd : e.alu));
        chk("regwrite",  64'(regwrite),  64'((n > 0) && e.ctrl[1] && (e.wr != 5'd0)));
    endtask

    // Check, advance the model by the handshakes implied by current inputs,
    // then move one clock edge forward.
    task automatic step();
        ent_t in_e;
        bit   in_acc;
        bit   out_acc;
        check_outputs();
        in_e    = '{ctrl: control_wb_in, rd: read_data_in, alu: alu_result_in, wr: write_reg_in};
        in_acc  = in_valid && (sb.size() < 2);
        out_acc = out_ready && (sb.size() > 0);
        if (rst) begin
            sb.delete();
            last = '0;
        end else if (flush) begin
            if (sb.size() > 0) last = sb[0];
            sb.delete();
        end else begin
            if (out_acc) void'(sb.pop_front());
            if (in_acc) sb.push_back(in_e);
            if (sb.size() > 0) last = sb[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [31:0] rd, input logic [31:0] alu,
                        input logic [4:0] wr);
        in_valid      = 1'b1;
        control_wb_in = c;
        read_data_in  = rd;
        alu_result_in = alu;
        write_reg_in  = wr;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        control_wb_in = '0; read_data_in = '0; alu_result_in = '0; write_reg_in = '0;
`ifdef MEM_WB_PIPE_FWD_EN
        fwd_rs = '0; fwd_rt = '0;
`endif
        last = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state then idle
        step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wb_data", 64'(wb_data), 64'd0);

        // Single entry, 1-cycle latency
        out_ready = 1'b1;
        send(2'b11, 32'h55, 32'h10, 5'd5);
        step();
        in_valid = 1'b0;
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_regwrite", 64'(regwrite), 64'd1);
        chk("lat_wb_data", 64'(wb_data), 64'h55);

        // 8 back-to-back entries at full throughput
        for (int i = 0; i < 8; i++) begin
            send(2'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 5'(i + 1));
            step();
            chk("stream_count", 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        step();
        step();

        // Stall: A and B fill main and skid; C is refused while full
        out_ready = 1'b0;
        send(2'b10, 32'hA0, 32'hAA, 5'd10);
        step();
        send(2'b01, 32'hB0, 32'hBB, 5'd11);
        step();
        chk("full_count", 64'(count), 64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_shows_a", 64'(mem_alu_result), 64'hAA);
        send(2'b11, 32'hC0, 32'hCC, 5'd12);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("drain_b", 64'(wb_data), 64'hB0);
        step();
        chk("drain_in_ready", 64'(in_ready), 64'd1);
        chk("drain_hold", 64'(mem_alu_result), 64'hBB);

        // Register 0 suppresses regwrite; memtoreg=0 selects the ALU result
        out_ready = 1'b0;
        send(2'b10, 32'h1, 32'h2, 5'd0);
        step();
        chk("r0_valid", 64'(out_valid), 64'd1);
        chk("r0_regwrite", 64'(regwrite), 64'd0);
        out_ready = 1'b1;
        send(2'b00, 32'hFF, 32'h7, 5'd3);
        step();
        in_valid = 1'b0;
        chk("alu_wb_data", 64'(wb_data), 64'h7);
        chk("alu_regwrite", 64'(regwrite), 64'd0);
        step();

        // Flush with two held entries and a simultaneous input
        out_ready = 1'b0;
        send(2'b11, 32'hD1, 32'hE1, 5'd7);
        step();
        send(2'b11, 32'hD2, 32'hE2, 5'd8);
        step();
        flush = 1'b1;
        send(2'b11, 32'hD3, 32'hE3, 5'd9);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_regwrite", 64'(regwrite), 64'd0);
        chk("flush_data_held", 64'(mem_alu_result), 64'hE1);
        out_ready = 1'b1;
        step();

        // Reset mid-transfer
        out_ready = 1'b0;
        send(2'b11, 32'h31, 32'h41, 5'd4);
        step();
        send(2'b11, 32'h32, 32'h42, 5'd6);
        step();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_read_data", 64'(read_data), 64'd0);

`ifdef MEM_WB_PIPE_FWD_EN
        send(2'b10, 32'h0, 32'h20, 5'd9);
        step();
        in_valid = 1'b0;
        fwd_rs = 5'd9;
        fwd_rt = 5'd3;
        #1;
        chk("fwd_rs_hit", 64'(fwd_rs_hit), 64'd1);
        chk("fwd_rt_hit", 64'(fwd_rt_hit), 64'd0);
        chk("fwd_data", 64'(fwd_data), 64'h20);
        out_ready = 1'b1;
        step();
        chk("fwd_idle_hit", 64'(fwd_rs_hit), 64'd0);
`endif

        // Random mix of stalls, bursts and occasional flushes
        for (int i = 0; i < 200; i++) begin
            in_valid      = 1'($urandom_range(0, 1));
            out_ready     = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 15) == 0);
            control_wb_in = 2'($urandom_range(0, 3));
            read_data_in  = $urandom;
            alu_result_in = $urandom;
            write_reg_in  = 5'($urandom_range(0, 31));
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
